// File: rtl/secp256k1_jb_to_affine_if.sv
// Single-beat stream interface shared by the multiply request and result channels.
interface if_axi_stream #(
  parameter int unsigned DAT_BITS = 256,
  parameter int unsigned CTL_BITS = 16,
  parameter int unsigned MOD_BITS = 6
);
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;
  logic [MOD_BITS-1:0] mod;

  modport source (output val, sop, eop, err, dat, ctl, mod, input rdy);
  modport sink   (input val, sop, eop, err, dat, ctl, mod, output rdy);
endinterface

// File: rtl/secp256k1_jb_to_affine.sv
// Jacobian -> affine conversion for secp256k1; Z^-1 by Fermat inversion over a
// shared external multiply-mod port, one multiply outstanding at a time.
package secp256k1_jb_to_affine_pkg;
  localparam int unsigned FE_BITS = 256;
  typedef struct packed {
    logic [FE_BITS-1:0] x;
    logic [FE_BITS-1:0] y;
    logic [FE_BITS-1:0] z;
  } jb_point_t;
endpackage

module secp256k1_jb_to_affine
  import secp256k1_jb_to_affine_pkg::*;
#(
  parameter logic [255:0] EXP      = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D,
  parameter int unsigned  CTL_BITS = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  jb_point_t    i_p,
  input  logic         i_val,
  output logic         o_rdy,
  output logic [255:0] o_x,
  output logic [255:0] o_y,
  output logic         o_val,
  input  logic         i_rdy,
  output logic         o_err,
  if_axi_stream.source o_mult_if,
  if_axi_stream.sink   i_mult_if
);
  localparam int unsigned W        = 256;
  localparam int unsigned TAG_BITS = 8;
  localparam int unsigned IDX_BITS = 8;

  typedef enum logic [3:0] {
    IDLE, INV_SQ, INV_MUL, NEXT, ZI2, ZI3, AX, AY, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        x_q, x_d, y_q, y_d, z_q, z_d;
  logic [W-1:0]        acc_q, acc_d, zi2_q, zi2_d, zi3_q, zi3_d;
  logic [W-1:0]        ox_q, ox_d, oy_q, oy_d;
  logic [W-1:0]        req_a_q, req_a_d, req_b_q, req_b_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic                req_val_q, req_val_d, res_rdy_q, res_rdy_d;
  logic                rdy_q, rdy_d, val_q, val_d, err_q, err_d;

  logic [W-1:0]        op_a_c, op_b_c;
  logic                mul_state_c, res_fire_c, res_bad_c;
  logic                unused_c;

  assign mul_state_c = state_q inside {INV_SQ, INV_MUL, ZI2, ZI3, AX, AY};
  assign res_fire_c  = res_rdy_q && i_mult_if.val;
  assign res_bad_c   = i_mult_if.err || (i_mult_if.ctl[TAG_BITS-1:0] != tag_q);
  assign unused_c    = ^{i_mult_if.sop, i_mult_if.eop, i_mult_if.mod,
                         i_mult_if.ctl[CTL_BITS-1:TAG_BITS]};

  // Operand selection for the multiply issued by the current state.
  always_comb begin
    op_a_c = acc_q;
    op_b_c = acc_q;
    unique case (state_q)
      INV_MUL: begin op_a_c = acc_q; op_b_c = z_q;   end
      ZI3:     begin op_a_c = zi2_q; op_b_c = acc_q; end
      AX:      begin op_a_c = x_q;   op_b_c = zi2_q; end
      AY:      begin op_a_c = y_q;   op_b_c = zi3_q; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    acc_d     = acc_q;
    zi2_d     = zi2_q;
    zi3_d     = zi3_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    req_a_d   = req_a_q;
    req_b_d   = req_b_q;
    idx_d     = idx_q;
    tag_d     = tag_q;
    req_val_d = req_val_q;
    res_rdy_d = res_rdy_q;
    rdy_d     = 1'b0;
    val_d     = val_q;
    err_d     = err_q;

    // Request channel: raise once per multiply state, drop after handshake.
    if (mul_state_c && !req_val_q && !res_rdy_q) begin
      req_val_d = 1'b1;
      req_a_d   = op_a_c;
      req_b_d   = op_b_c;
    end
    if (req_val_q && o_mult_if.rdy) begin
      req_val_d = 1'b0;
      res_rdy_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (i_val && rdy_q) begin
          rdy_d = 1'b0;
          x_d   = i_p.x;
          y_d   = i_p.y;
          z_d   = i_p.z;
          if (i_p.z == '0) begin
            state_d = DONE;
            val_d   = 1'b1;
            err_d   = 1'b1;
            ox_d    = '0;
            oy_d    = '0;
          end else if (i_p.z == W'(1)) begin
            state_d = DONE;
            val_d   = 1'b1;
            ox_d    = i_p.x;
            oy_d    = i_p.y;
          end else begin
            // EXP[255] is consumed by starting the accumulator at Z.
            acc_d   = i_p.z;
            idx_d   = IDX_BITS'(W - 2);
            state_d = INV_SQ;
          end
        end
      end
      NEXT: begin
        if (idx_q == '0) begin
          state_d = ZI2;
        end else begin
          idx_d   = idx_q - IDX_BITS'(1);
          state_d = INV_SQ;
        end
      end
      DONE: begin
        if (i_rdy) begin
          val_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        if (res_fire_c) begin
          res_rdy_d = 1'b0;
          tag_d     = tag_q + TAG_BITS'(1);
          if (res_bad_c) begin
            state_d = DONE;
            val_d   = 1'b1;
            err_d   = 1'b1;
            ox_d    = '0;
            oy_d    = '0;
          end else begin
            unique case (state_q)
              INV_SQ: begin
                acc_d   = i_mult_if.dat;
                state_d = EXP[idx_q] ? INV_MUL : NEXT;
              end
              INV_MUL: begin acc_d = i_mult_if.dat; state_d = NEXT; end
              ZI2:     begin zi2_d = i_mult_if.dat; state_d = ZI3;  end
              ZI3:     begin zi3_d = i_mult_if.dat; state_d = AX;   end
              // zi2 is dead after AX is issued, so it parks affine x until DONE.
              AX:      begin zi2_d = i_mult_if.dat; state_d = AY;   end
              AY: begin
                ox_d    = zi2_q;
                oy_d    = i_mult_if.dat;
                val_d   = 1'b1;
                state_d = DONE;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      acc_q     <= '0;
      zi2_q     <= '0;
      zi3_q     <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      req_a_q   <= '0;
      req_b_q   <= '0;
      idx_q     <= '0;
      tag_q     <= '0;
      req_val_q <= 1'b0;
      res_rdy_q <= 1'b0;
      rdy_q     <= 1'b0;
      val_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      acc_q     <= acc_d;
      zi2_q     <= zi2_d;
      zi3_q     <= zi3_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      req_a_q   <= req_a_d;
      req_b_q   <= req_b_d;
      idx_q     <= idx_d;
      tag_q     <= tag_d;
      req_val_q <= req_val_d;
      res_rdy_q <= res_rdy_d;
      rdy_q     <= rdy_d;
      val_q     <= val_d;
      err_q     <= err_d;
    end
  end

  assign o_rdy         = rdy_q;
  assign o_x           = ox_q;
  assign o_y           = oy_q;
  assign o_val         = val_q;
  assign o_err         = err_q;
  assign o_mult_if.val = req_val_q;
  assign o_mult_if.dat = {req_b_q, req_a_q};
  assign o_mult_if.ctl = CTL_BITS'(tag_q);
  assign o_mult_if.sop = 1'b1;
  assign o_mult_if.eop = 1'b1;
  assign o_mult_if.err = 1'b0;
  assign o_mult_if.mod = '0;
  assign i_mult_if.rdy = res_rdy_q;

endmodule

// File: tb/tb_secp256k1_jb_to_affine.sv
// Bench for secp256k1_jb_to_affine: behavioural multiply-mod responder plus directed points.
module tb_secp256k1_jb_to_affine;
  import secp256k1_jb_to_affine_pkg::*;

  localparam logic [255:0] P   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] GX  = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] GY  = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
  localparam logic [255:0] X2G = 256'hC6047F94_41ED7D6D_3045406E_95C07CD8_5C778E4B_8CEF3CA7_ABAC09B9_5C709EE5;
  localparam logic [255:0] Y2G = 256'h1AE168FE_A63DC339_A3C58419_466CEAEE_F7F63265_3266D0E1_236431A9_50CFE52A;
  localparam logic [255:0] X3G = 256'hF9308A01_9258C310_49344F85_F89D5229_B531C845_836F99B0_8601F113_BCE036F9;
  localparam logic [255:0] Y3G = 256'h388F7B0F_632DE814_0FE337E6_2A37F356_6500A999_34C2231B_6CB9FD75_84B8E672;
  localparam logic [255:0] ZK  = 256'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_01122334_45566778_899AABBC_CDDEEFF0;
  localparam int MAX_CYC = 20000;

  logic         clk, rst;
  jb_point_t    i_p;
  logic         i_val, o_rdy, o_val, i_rdy, o_err;
  logic [255:0] o_x, o_y;

  if_axi_stream #(.DAT_BITS(512), .CTL_BITS(16)) req_if ();
  if_axi_stream #(.DAT_BITS(256), .CTL_BITS(16)) res_if ();

  secp256k1_jb_to_affine dut (
    .i_clk(clk), .i_rst(rst), .i_p(i_p), .i_val(i_val), .o_rdy(o_rdy),
    .o_x(o_x), .o_y(o_y), .o_val(o_val), .i_rdy(i_rdy), .o_err(o_err),
    .o_mult_if(req_if), .i_mult_if(res_if)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Responder bookkeeping (written only by the responder process).
  int           req_cnt = 0, tag_breaks = 0, fmt_errs = 0, overlaps = 0;
  logic [255:0] cap_a, cap_b;
  // Responder controls (written only by the main process).
  logic         stall_en = 1'b0;
  int           bad_at = 0, cap_at = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] prod;
    prod = {256'b0, a} * {256'b0, b};
    return 256'(prod % {256'b0, P});
  endfunction

  function automatic jb_point_t mk(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z);
    jb_point_t p;
    p.x = x; p.y = y; p.z = z;
    return p;
  endfunction

  // Multiply-mod responder: one beat per request, optional random stalls.
  initial begin
    logic         qf, rf, fmt_ok, pend, have_last;
    logic [511:0] qd;
    logic [15:0]  qc;
    logic [255:0] p_dat;
    logic [7:0]   p_tag, last_tag;
    int           delay;
    pend = 1'b0; have_last = 1'b0; delay = 0; last_tag = '0; p_dat = '0; p_tag = '0;
    req_if.rdy = 1'b0;
    res_if.val = 1'b0; res_if.dat = '0; res_if.ctl = '0; res_if.err = 1'b0;
    res_if.sop = 1'b1; res_if.eop = 1'b1; res_if.mod = '0;
    forever begin
      @(negedge clk);
      qf = req_if.val && req_if.rdy;
      rf = res_if.val && res_if.rdy;
      qd = req_if.dat;
      qc = req_if.ctl;
      fmt_ok = req_if.sop && req_if.eop && !req_if.err && (req_if.mod == '0) && (qc[15:8] == 8'h00);
      @(posedge clk); #1;
      if (rst) begin
        req_if.rdy = 1'b0; res_if.val = 1'b0; pend = 1'b0; have_last = 1'b0;
      end else begin
        if (rf) begin res_if.val = 1'b0; pend = 1'b0; end
        if (qf) begin
          req_cnt++;
          if (pend) overlaps++;
          if (!fmt_ok) fmt_errs++;
          if (have_last && (qc[7:0] !== 8'(last_tag + 8'd1))) tag_breaks++;
          last_tag = qc[7:0]; have_last = 1'b1;
          if (req_cnt == cap_at) begin cap_a = qd[255:0]; cap_b = qd[511:256]; end
          p_dat = mulmod(qd[255:0], qd[511:256]);
          p_tag = (req_cnt == bad_at) ? (qc[7:0] ^ 8'h5A) : qc[7:0];
          delay = stall_en ? int'($urandom_range(0, 3)) : 0;
          pend  = 1'b1;
        end
        if (pend && !res_if.val) begin
          if (delay == 0) begin
            res_if.val = 1'b1; res_if.dat = p_dat; res_if.ctl = {8'h00, p_tag};
          end else delay--;
        end
        req_if.rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Present one point, wait for the result, hold i_rdy low for `hold` cycles, then consume it.
  task automatic do_conv(input jb_point_t p, input int hold,
                         output logic [255:0] x, output logic [255:0] y, output logic err,
                         output logic done, output int lat, output logic stable);
    int n;
    done = 1'b0; stable = 1'b1; lat = 0; x = '0; y = '0; err = 1'b0;
    n = 0;
    while (!o_rdy && n < 100) begin @(posedge clk); #1; n++; end
    i_p = p; i_val = 1'b1;
    @(posedge clk); #1;
    i_val = 1'b0;
    n = 0;
    while (!o_val && n < MAX_CYC) begin @(posedge clk); #1; n++; end
    lat = n;
    if (o_val) begin
      done = 1'b1; x = o_x; y = o_y; err = o_err;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!o_val || o_x !== x || o_y !== y || o_err !== err) stable = 1'b0;
      end
      i_rdy = 1'b1;
      @(posedge clk); #1;
      i_rdy = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (o_rdy !== 1'b0 || o_val !== 1'b0 || o_err !== 1'b0) begin n_fails++;
      $display("FAIL reset_flags: got rdy=%0b val=%0b err=%0b want 0 0 0", o_rdy, o_val, o_err); end
    n_checks++; if (o_x !== '0 || o_y !== '0) begin n_fails++;
      $display("FAIL reset_xy: got x=%h y=%h want 0", o_x, o_y); end
    n_checks++; if (req_if.val !== 1'b0 || res_if.rdy !== 1'b0) begin n_fails++;
      $display("FAIL reset_mult: got req_val=%0b res_rdy=%0b want 0 0", req_if.val, res_if.rdy); end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (o_rdy !== 1'b1) begin n_fails++;
      $display("FAIL reset_rdy_rise: got %0b want 1", o_rdy); end
  endtask

  task automatic test_z_one;
    logic [255:0] x, y; logic err, done, st; int lat, base;
    base = req_cnt;
    do_conv(mk(GX, GY, 256'd1), 0, x, y, err, done, lat, st);
    n_checks++; if (!done || x !== GX || y !== GY || err !== 1'b0) begin n_fails++;
      $display("FAIL z_one: got done=%0b x=%h y=%h err=%0b want x=%h y=%h err=0", done, x, y, err, GX, GY); end
    n_checks++; if (req_cnt - base != 0) begin n_fails++;
      $display("FAIL z_one_reqs: got %0d want 0", req_cnt - base); end
  endtask

  task automatic test_z_two;
    logic [255:0] x, y; logic err, done, st; int lat, base, tb0, fe0, ov0;
    base = req_cnt; tb0 = tag_breaks; fe0 = fmt_errs; ov0 = overlaps;
    do_conv(mk(mulmod(256'd4, GX), mulmod(256'd8, GY), 256'd2), 0, x, y, err, done, lat, st);
    n_checks++; if (!done || x !== GX || y !== GY || err !== 1'b0) begin n_fails++;
      $display("FAIL z_two: got done=%0b x=%h y=%h err=%0b want x=%h y=%h err=0", done, x, y, err, GX, GY); end
    n_checks++; if (req_cnt - base != 507) begin n_fails++;
      $display("FAIL z_two_reqs: got %0d want 507", req_cnt - base); end
    n_checks++; if (tag_breaks != tb0 || fmt_errs != fe0 || overlaps != ov0) begin n_fails++;
      $display("FAIL z_two_proto: got tag_breaks=%0d fmt=%0d overlap=%0d want 0 0 0",
               tag_breaks - tb0, fmt_errs - fe0, overlaps - ov0); end
  endtask

  task automatic test_3g;
    logic [255:0] x, y, z2; logic err, done, st; int lat, base;
    base = req_cnt;
    cap_at = base + 504;
    z2 = mulmod(ZK, ZK);
    do_conv(mk(mulmod(X3G, z2), mulmod(Y3G, mulmod(z2, ZK)), ZK), 0, x, y, err, done, lat, st);
    n_checks++; if (!done || x !== X3G || y !== Y3G || err !== 1'b0) begin n_fails++;
      $display("FAIL k3g: got done=%0b x=%h y=%h err=%0b want x=%h y=%h err=0", done, x, y, err, X3G, Y3G); end
    n_checks++; if (cap_a !== cap_b || mulmod(cap_a, ZK) !== 256'd1) begin n_fails++;
      $display("FAIL k3g_zinv: got a=%h b=%h a*Z=%h want a==b and a*Z=1", cap_a, cap_b, mulmod(cap_a, ZK)); end
    cap_at = 0;
  endtask

  task automatic test_z_zero;
    logic [255:0] x, y; logic err, done, st; int lat, base;
    base = req_cnt;
    do_conv(mk(GX, GY, 256'd0), 0, x, y, err, done, lat, st);
    n_checks++; if (!done || err !== 1'b1 || lat > 3) begin n_fails++;
      $display("FAIL z_zero: got done=%0b err=%0b lat=%0d want 1 1 <=3", done, err, lat); end
    n_checks++; if (x !== '0 || y !== '0 || req_cnt - base != 0) begin n_fails++;
      $display("FAIL z_zero_out: got x=%h y=%h reqs=%0d want 0 0 0", x, y, req_cnt - base); end
    do_conv(mk(X2G, Y2G, 256'd1), 0, x, y, err, done, lat, st);
    n_checks++; if (!done || x !== X2G || y !== Y2G || err !== 1'b0) begin n_fails++;
      $display("FAIL z_zero_next: got done=%0b x=%h y=%h err=%0b want x=%h y=%h err=0", done, x, y, err, X2G, Y2G); end
  endtask

  task automatic test_stall;
    logic [255:0] x, y, z2; logic err, done, st; int lat;
    stall_en = 1'b1;
    z2 = mulmod(ZK, ZK);
    do_conv(mk(mulmod(X3G, z2), mulmod(Y3G, mulmod(z2, ZK)), ZK), 20, x, y, err, done, lat, st);
    stall_en = 1'b0;
    n_checks++; if (!done || x !== X3G || y !== Y3G || err !== 1'b0) begin n_fails++;
      $display("FAIL stall: got done=%0b x=%h y=%h err=%0b want x=%h y=%h err=0", done, x, y, err, X3G, Y3G); end
    n_checks++; if (st !== 1'b1) begin n_fails++;
      $display("FAIL stall_hold: got stable=%0b want 1", st); end
  endtask

  task automatic test_bad_tag;
    logic [255:0] x, y; logic err, done, st; int lat, base;
    base = req_cnt;
    bad_at = base + 100;
    do_conv(mk(mulmod(256'd4, GX), mulmod(256'd8, GY), 256'd2), 0, x, y, err, done, lat, st);
    repeat (20) @(posedge clk);
    #1;
    bad_at = 0;
    n_checks++; if (!done || err !== 1'b1) begin n_fails++;
      $display("FAIL bad_tag: got done=%0b err=%0b want 1 1", done, err); end
    n_checks++; if (req_cnt - base != 100) begin n_fails++;
      $display("FAIL bad_tag_reqs: got %0d want 100", req_cnt - base); end
  endtask

  task automatic test_reset_mid;
    logic [255:0] x, y, z2; logic err, done, st; int lat, base, n;
    base = req_cnt;
    n = 0;
    while (!o_rdy && n < 100) begin @(posedge clk); #1; n++; end
    i_p = mk(mulmod(256'd4, GX), mulmod(256'd8, GY), 256'd2); i_val = 1'b1;
    @(posedge clk); #1;
    i_val = 1'b0;
    n = 0;
    while (req_cnt - base < 300 && n < MAX_CYC) begin @(posedge clk); #1; n++; end
    n_checks++; if (req_cnt - base < 300) begin n_fails++;
      $display("FAIL reset_mid_reach: got %0d reqs want 300", req_cnt - base); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (o_val !== 1'b0 || o_rdy !== 1'b0 || req_if.val !== 1'b0 || res_if.rdy !== 1'b0 || o_x !== '0) begin
      n_fails++;
      $display("FAIL reset_mid_clear: got val=%0b rdy=%0b req_val=%0b res_rdy=%0b x=%h want all 0",
               o_val, o_rdy, req_if.val, res_if.rdy, o_x); end
    @(posedge clk); #3;
    rst = 1'b0;
    base = req_cnt;
    z2 = mulmod(ZK, ZK);
    do_conv(mk(mulmod(X3G, z2), mulmod(Y3G, mulmod(z2, ZK)), ZK), 0, x, y, err, done, lat, st);
    n_checks++; if (!done || x !== X3G || y !== Y3G || err !== 1'b0) begin n_fails++;
      $display("FAIL reset_mid_fresh: got done=%0b x=%h y=%h err=%0b want x=%h y=%h err=0", done, x, y, err, X3G, Y3G); end
    n_checks++; if (req_cnt - base != 507) begin n_fails++;
      $display("FAIL reset_mid_reqs: got %0d want 507", req_cnt - base); end
  endtask

  initial begin
    rst = 1'b1; i_val = 1'b0; i_rdy = 1'b0; i_p = '0;
    test_reset;
    test_z_one;
    test_z_two;
    test_3g;
    test_z_zero;
    test_stall;
    test_bad_tag;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
